// File: rtl/y_run_length_encoder.sv
// Run-length encoder for the y bit stream: turns valid samples into (bit, length) tokens
// held in a show-ahead FIFO; a full FIFO without a same-cycle pop drops the token and flags it.
module y_run_length_encoder #(
  parameter int LEN_W = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             y_in,
  input  logic             y_valid,
  input  logic             flush,
  output logic             tok_valid,
  input  logic             tok_ready,
  output logic             tok_bit,
  output logic [LEN_W-1:0] tok_len,
  output logic [CNT_W-1:0] fifo_count,
  output logic             overflow_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [LEN_W-1:0] MAX_LEN = '1;

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic             val;
    logic [LEN_W-1:0] len;
  } tok_t;

  state_t           state_q, state_d;
  logic             cur_bit_q, cur_bit_d;
  logic [LEN_W-1:0] run_len_q, run_len_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  tok_t             hold_q, hold_d;
  tok_t             mem_q [DEPTH];
  tok_t             mem_d [DEPTH];

  logic push, pop, wr_en, empty, full;
  tok_t push_tok, head;

  // Run tracker: decides whether this cycle closes the open run.
  always_comb begin
    state_d   = state_q;
    cur_bit_d = cur_bit_q;
    run_len_d = run_len_q;
    push      = 1'b0;
    push_tok  = '{val: cur_bit_q, len: run_len_q};
    case (state_q)
      IDLE: begin
        if (y_valid) begin
          state_d   = RUN;
          cur_bit_d = y_in;
          run_len_d = LEN_W'(1);
        end
      end
      RUN: begin
        if (y_valid) begin
          if ((y_in != cur_bit_q) || (run_len_q == MAX_LEN) || flush) begin
            push      = 1'b1;
            cur_bit_d = y_in;
            run_len_d = LEN_W'(1);
          end else begin
            run_len_d = run_len_q + 1'b1;
          end
        end else if (flush) begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign pop   = !empty && tok_ready;
  // A full FIFO still takes the push when the head leaves in the same cycle.
  assign wr_en = push && (!full || pop);

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_ptr_q] = push_tok;
    wr_ptr_d   = wr_ptr_q + PTR_W'(wr_en);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    count_d    = count_q + CNT_W'(wr_en) - CNT_W'(pop);
    overflow_d = overflow_q | (push && full && !pop);
    hold_d     = pop ? mem_q[rd_ptr_q] : hold_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cur_bit_q  <= 1'b0;
      run_len_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      cur_bit_q  <= cur_bit_d;
      run_len_q  <= run_len_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      hold_q     <= hold_d;
    end
  end

  // Storage needs no reset: it is only read while count_q says the slot is live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Once drained, the outputs keep showing the last token that left.
  assign head         = empty ? hold_q : mem_q[rd_ptr_q];
  assign tok_valid    = !empty;
  assign tok_bit      = head.val;
  assign tok_len      = head.len;
  assign fifo_count   = count_q;
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_y_run_length_encoder.sv
// Scoreboard bench for y_run_length_encoder: driver feeds a sample-queue reference model,
// a negedge monitor compares every presented token and the FIFO status outputs.
module tb_y_run_length_encoder;
  localparam int LEN_W   = 4;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int MAX_LEN = (1 << LEN_W) - 1;

  logic             clk = 1'b0;
  logic             reset, y_in, y_valid, flush, tok_ready;
  logic             tok_valid, tok_bit, overflow_err;
  logic [LEN_W-1:0] tok_len;
  logic [CNT_W-1:0] fifo_count;

  always #5 clk = ~clk;

  y_run_length_encoder #(.LEN_W(LEN_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .y_in(y_in), .y_valid(y_valid), .flush(flush),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_bit(tok_bit), .tok_len(tok_len),
    .fifo_count(fifo_count), .overflow_err(overflow_err)
  );

  logic [LEN_W:0]   exp_q [$];   // {bit, len} of tokens the FIFO should hold, oldest first
  bit               run_q [$];   // samples of the currently open run
  int               m_cnt, m_push, exp_cnt_cur;
  bit               m_ovf, exp_ovf_cur, mon_en;
  logic             last_bit;
  logic [LEN_W-1:0] last_len;
  int               total, bad;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
    end
  endtask

  // Close the open run into a token; it lands only if the FIFO has room after this edge's pop.
  task automatic emit(input bit pop);
    logic [LEN_W:0] tok;
    if (run_q.size() == 0) return;
    tok = {run_q[0], LEN_W'(run_q.size())};
    if (m_cnt < DEPTH || pop) begin
      exp_q.push_back(tok);
      m_push = 1;
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic step(input bit r, input bit v, input bit yb, input bit f, input bit rdy);
    bit pop;
    @(posedge clk);
    #2;
    exp_cnt_cur = m_cnt;
    exp_ovf_cur = m_ovf;
    reset = r; y_valid = v; y_in = yb; flush = f; tok_ready = rdy;
    if (r) begin
      run_q.delete();
      exp_q.delete();
      m_cnt = 0;
      m_ovf = 1'b0;
    end else begin
      pop    = (m_cnt > 0) && rdy;
      m_push = 0;
      if (v) begin
        if (run_q.size() > 0 && (yb != run_q[0] || run_q.size() == MAX_LEN || f)) begin
          emit(pop);
          run_q.delete();
        end
        run_q.push_back(yb);
      end else if (f) begin
        emit(pop);
        run_q.delete();
      end
      m_cnt = m_cnt - int'(pop) + m_push;
    end
  endtask

  initial begin
    logic [LEN_W:0] t;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("fifo_count", 32'(fifo_count), 32'(exp_cnt_cur));
        check("overflow_err", 32'(overflow_err), 32'(exp_ovf_cur));
        check("tok_valid", 32'(tok_valid), 32'(exp_cnt_cur != 0));
        if (!tok_valid) begin
          check("hold_bit", 32'(tok_bit), 32'(last_bit));
          check("hold_len", 32'(tok_len), 32'(last_len));
        end else if (!reset) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL token_unexpected: got (%0d,%0d) want none at %0t", tok_bit, tok_len, $time);
          end else begin
            t = exp_q[0];
            check("tok_bit", 32'(tok_bit), 32'(t[LEN_W]));
            check("tok_len", 32'(tok_len), 32'(t[LEN_W-1:0]));
            if (tok_ready) begin
              t = exp_q.pop_front();
              last_bit = t[LEN_W];
              last_len = t[LEN_W-1:0];
            end
          end
        end
        if (reset) begin
          last_bit = 1'b0;
          last_len = '0;
        end
      end
    end
  end

  initial begin
    bit cur_y, rdy;
    reset = 1'b1; y_in = 1'b0; y_valid = 1'b0; flush = 1'b0; tok_ready = 1'b0;
    m_cnt = 0; m_ovf = 1'b0; exp_cnt_cur = 0; exp_ovf_cur = 1'b0;
    last_bit = 1'b0; last_len = '0; total = 0; bad = 0; mon_en = 1'b0;

    step(1, 0, 0, 0, 0);
    mon_en = 1'b1;
    repeat (5) step(0, 0, 0, 0, 0);

    // 1,1,1,0,0 then flush
    repeat (3) step(0, 1, 1, 0, 1);
    repeat (2) step(0, 1, 0, 0, 1);
    step(0, 0, 0, 1, 1);
    repeat (3) step(0, 0, 0, 0, 1);

    // 17 ones: one maximal run plus a run of two
    repeat (17) step(0, 1, 1, 0, 1);
    step(0, 0, 0, 1, 1);
    repeat (4) step(0, 0, 0, 0, 1);

    // alternating bits into a stalled FIFO, then drain
    for (int i = 0; i < 6; i++) step(0, 1, i[0], 0, 0);
    repeat (2) step(0, 0, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 1);
    repeat (2) step(0, 0, 0, 0, 1);

    // flush together with a sample that continues the run
    repeat (2) step(0, 1, 1, 0, 1);
    step(0, 1, 1, 1, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 1);
    repeat (2) step(0, 0, 0, 0, 1);

    // two tokens buffered and a run of five open, then reset
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    repeat (5) step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1);
    repeat (3) step(0, 0, 0, 0, 1);

    cur_y = 1'b0;
    rdy   = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) cur_y = ~cur_y;
      if ($urandom_range(0, 7) == 0) rdy = ~rdy;
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 3) != 0), cur_y,
           ($urandom_range(0, 19) == 0), rdy);
    end

    step(0, 0, 0, 1, 1);
    repeat (DEPTH + 3) step(0, 0, 0, 0, 1);
    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
